// File: rtl/cache_arbiter.sv
// Round-robin arbiter joining the split L1 instruction/data cache line ports onto one
// physical-memory port; serialises line transactions and steers responses back.
module cache_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int LINE_WIDTH  = 256,
   parameter int OFFSET_BITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_pmem_read,
   input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
   output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
   output logic                  icache_pmem_resp,
   input  logic                  dcache_pmem_read,
   input  logic                  dcache_pmem_write,
   input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
   input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
   output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
   output logic                  dcache_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
      {{(ADDR_WIDTH-OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  read_q, read_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic                  i_req_s;
   logic                  d_req_s;

   function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
      line_align = a & ~OFFSET_MASK;
   endfunction

   assign i_req_s = icache_pmem_read;
   assign d_req_s = dcache_pmem_read | dcache_pmem_write;

   assign pmem_read    = read_q;
   assign pmem_write   = write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;

   assign icache_pmem_rdata = pmem_rdata;
   assign dcache_pmem_rdata = pmem_rdata;
   // rst gating keeps a response from leaking out of a transaction being aborted
   assign icache_pmem_resp  = pmem_resp & ~rst & (state_q == SERVE_I);
   assign dcache_pmem_resp  = pmem_resp & ~rst & (state_q == SERVE_D);

   // Next-state, grant selection and transaction latch update
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      read_d       = read_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      case (state_q)
         IDLE: begin
            // On a tie the side not granted last time wins
            if (i_req_s && (!d_req_s || last_grant_q)) begin
               state_d      = SERVE_I;
               last_grant_d = 1'b0;
               read_d       = 1'b1;
               write_d      = 1'b0;
               addr_d       = line_align(icache_pmem_address);
               wdata_d      = dcache_pmem_wdata;
            end else if (d_req_s) begin
               state_d      = SERVE_D;
               last_grant_d = 1'b1;
               read_d       = ~dcache_pmem_write;
               write_d      = dcache_pmem_write;
               addr_d       = line_align(dcache_pmem_address);
               wdata_d      = dcache_pmem_wdata;
            end else begin
               state_d = IDLE;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) begin
               state_d = IDLE;
               read_d  = 1'b0;
               write_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
         end
      endcase
   end

   // State and transaction registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= {ADDR_WIDTH{1'b0}};
         wdata_q      <= {LINE_WIDTH{1'b0}};
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         read_q       <= read_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a scoreboard queue of expected memory transactions
// is filled as requests are raised and drained as the arbiter issues and completes them.
module tb_cache_arbiter;

   logic         clk;
   logic         rst;
   logic         icache_pmem_read;
   logic [31:0]  icache_pmem_address;
   logic [255:0] icache_pmem_rdata;
   logic         icache_pmem_resp;
   logic         dcache_pmem_read;
   logic         dcache_pmem_write;
   logic [31:0]  dcache_pmem_address;
   logic [255:0] dcache_pmem_wdata;
   logic [255:0] dcache_pmem_rdata;
   logic         dcache_pmem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   typedef struct packed {
      logic         side;   // 0 = I, 1 = D
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   cache_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .OFFSET_BITS(5)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .icache_pmem_read    (icache_pmem_read),
      .icache_pmem_address (icache_pmem_address),
      .icache_pmem_rdata   (icache_pmem_rdata),
      .icache_pmem_resp    (icache_pmem_resp),
      .dcache_pmem_read    (dcache_pmem_read),
      .dcache_pmem_write   (dcache_pmem_write),
      .dcache_pmem_address (dcache_pmem_address),
      .dcache_pmem_wdata   (dcache_pmem_wdata),
      .dcache_pmem_rdata   (dcache_pmem_rdata),
      .dcache_pmem_resp    (dcache_pmem_resp),
      .pmem_read           (pmem_read),
      .pmem_write          (pmem_write),
      .pmem_address        (pmem_address),
      .pmem_wdata          (pmem_wdata),
      .pmem_rdata          (pmem_rdata),
      .pmem_resp           (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic do_reset();
      rst                 = 1'b1;
      icache_pmem_read    = 1'b0;
      dcache_pmem_read    = 1'b0;
      dcache_pmem_write   = 1'b0;
      pmem_resp           = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic req_i(input logic [31:0] addr);
      exp_t e;
      icache_pmem_read    = 1'b1;
      icache_pmem_address = addr;
      e.side  = 1'b0;
      e.wr    = 1'b0;
      e.addr  = {addr[31:5], 5'b00000};
      e.wdata = 256'd0;
      sb.push_back(e);
   endtask

   task automatic req_d(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wd);
      exp_t e;
      dcache_pmem_read    = rd;
      dcache_pmem_write   = wr;
      dcache_pmem_address = addr;
      dcache_pmem_wdata   = wd;
      e.side  = 1'b1;
      e.wr    = wr;
      e.addr  = {addr[31:5], 5'b00000};
      e.wdata = wd;
      sb.push_back(e);
   endtask

   // Wait for the next grant, check it against the scoreboard head, hold for lat
   // cycles, respond, then drop the served request and check the idle bubble.
   task automatic serve(input int exp_wait, input int lat);
      exp_t         e;
      int           n;
      logic [255:0] d;
      n = 0;
      while (!(pmem_read || pmem_write) && n < 20) begin
         tick();
         n++;
      end
      chk("grant_wait", n, exp_wait);
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL sb_underflow observed=grant expected=no_grant");
         return;
      end
      e = sb.pop_front();
      chk("pmem_read", pmem_read, !e.wr);
      chk("pmem_write", pmem_write, e.wr);
      chk("pmem_address", pmem_address, e.addr);
      if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
      for (int i = 0; i < lat; i++) begin
         if (e.side) begin
            dcache_pmem_address = $urandom();
            if (e.wr) dcache_pmem_wdata = rand_line();
         end else begin
            icache_pmem_address = $urandom();
         end
         tick();
         chk("hold_addr", pmem_address, e.addr);
         chk("hold_strobe", {pmem_read, pmem_write}, {!e.wr, e.wr});
         if (e.wr) chk("hold_wdata", pmem_wdata, e.wdata);
         chk("early_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
      end
      d          = rand_line();
      pmem_rdata = d;
      pmem_resp  = 1'b1;
      #1;
      chk("i_resp", icache_pmem_resp, !e.side);
      chk("d_resp", dcache_pmem_resp, e.side);
      chk("rdata", e.side ? dcache_pmem_rdata : icache_pmem_rdata, d);
      tick();
      pmem_resp = 1'b0;
      if (e.side) begin
         dcache_pmem_read  = 1'b0;
         dcache_pmem_write = 1'b0;
      end else begin
         icache_pmem_read = 1'b0;
      end
      #1;
      chk("bubble_strobe", {pmem_read, pmem_write}, 2'b00);
      chk("bubble_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
   endtask

   initial begin
      icache_pmem_address = 32'd0;
      dcache_pmem_address = 32'd0;
      dcache_pmem_wdata   = 256'd0;
      pmem_rdata          = 256'd0;
      do_reset();

      // reset values
      chk("rst_read", pmem_read, 1'b0);
      chk("rst_write", pmem_write, 1'b0);
      chk("rst_addr", pmem_address, 32'd0);
      chk("rst_wdata", pmem_wdata, 256'd0);
      chk("rst_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);

      // stray memory response in IDLE
      pmem_resp = 1'b1;
      #1;
      chk("idle_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
      tick();
      pmem_resp = 1'b0;
      chk("idle_strobe", {pmem_read, pmem_write}, 2'b00);

      // I read alone, then D write alone
      req_i(32'h0000_1234);
      serve(1, 4);
      req_d(1'b0, 1'b1, 32'h8000_00FF, rand_line());
      serve(1, 4);

      // tie straight after reset: I first, then again I first after D
      do_reset();
      req_i(32'h0000_2000);
      req_d(1'b1, 1'b0, 32'h0000_3010, 256'd0);
      serve(1, 3);
      serve(1, 2);
      req_i(32'h0000_2040);
      req_d(1'b0, 1'b1, 32'h0000_3060, rand_line());
      serve(1, 1);
      serve(1, 1);

      // after a lone I grant, a tie goes to D
      req_i(32'h0000_4444);
      serve(1, 2);
      req_d(1'b1, 1'b0, 32'h0000_5555, 256'd0);
      req_i(32'h0000_6666);
      serve(1, 2);
      serve(1, 2);

      // continuous contention: I, D, I, D, I, D
      do_reset();
      req_i(32'h1000_0000);
      req_d(1'b1, 1'b0, 32'h2000_0000, 256'd0);
      for (int t = 0; t < 6; t++) begin
         serve((t == 0) ? 1 : 0, 2);
         if (t < 5) tick();
         if (t < 4) begin
            if (t % 2 == 0) req_i(32'h1000_0000 + 32'(t * 32 + 7));
            else req_d(1'b0, 1'b1, 32'h2000_0000 + 32'(t * 32 + 9), rand_line());
         end
      end

      // D read and write together behaves as a write
      req_d(1'b1, 1'b1, 32'h0000_0040, rand_line());
      serve(1, 2);

      // reset in the middle of a D read
      dcache_pmem_read    = 1'b1;
      dcache_pmem_address = 32'h0000_0200;
      tick();
      chk("abort_strobe_on", pmem_read, 1'b1);
      tick();
      rst              = 1'b1;
      dcache_pmem_read = 1'b0;
      tick();
      rst = 1'b0;
      chk("abort_strobe_off", {pmem_read, pmem_write}, 2'b00);
      tick();
      tick();
      pmem_resp = 1'b1;
      #1;
      chk("abort_late_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
      tick();
      pmem_resp = 1'b0;
      req_i(32'h3000_0044);
      serve(1, 3);

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
